// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: default sizing and FSM states.
package mult_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_unit_if.sv
// Request/result bundle between the ID/EX operand stage and the multiplier.
interface mult_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Operand side drives the request and observes the result.
  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  // Multiplier side consumes the request and drives the result.
  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_add_stage.sv
// One partial-product step: WIDTH-bit ripple adder returning {carry, sum}.
module mult_add_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_addend,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b0;

  // Chain of full-adder cells, carry rippling from bit 0 upward.
  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    assign o_sum[g]       = i_acc[g] ^ i_addend[g] ^ w_carry[g];
    assign w_carry[g + 1] = (i_acc[g] & i_addend[g]) |
                            (w_carry[g] & (i_acc[g] ^ i_addend[g]));
  end

  assign o_sum[WIDTH] = w_carry[WIDTH];

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle MULT/MULTU unit: magnitudes are multiplied by shift-and-add,
// one partial product per clock, and the sign is applied in a final step.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic       clk,
  input logic       rst,
  mult_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_mag_a;
  logic               r_neg;
  // The carry of each add lands in the MSB after the shift, so the
  // accumulator's extra top bit is always zero and is not stored.
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_raw;
  logic [2*WIDTH-1:0] w_prod;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    w_mag_a = bus.a;
    w_mag_b = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) begin
      w_mag_a = ~bus.a + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_mag_a = bus.a;
    end
    if (bus.is_signed && bus.b[WIDTH-1]) begin
      w_mag_b = ~bus.b + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_mag_b = bus.b;
    end
  end

  // Multiplicand is added only when the current multiplier bit is set.
  always_comb begin
    w_addend = '0;
    if (r_mplr[0]) begin
      w_addend = r_mag_a;
    end else begin
      w_addend = '0;
    end
  end

  mult_add_stage #(.WIDTH(WIDTH)) u_add (
    .i_acc    (r_acc),
    .i_addend (w_addend),
    .o_sum    (w_sum)
  );

  // Final sign fix-up of the unsigned product.
  always_comb begin
    w_raw  = {r_acc, r_mplr};
    w_prod = w_raw;
    if (r_neg) begin
      w_prod = ~w_raw + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_prod = w_raw;
    end
  end

  // Control FSM with datapath registers and registered flags/results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mag_a <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mag_a <= w_mag_a;
            r_mplr  <= w_mag_b;
            r_neg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Shift {carry, sum, mplr} right by one place.
          r_acc   <= w_sum[WIDTH:1];
          r_mplr  <= {w_sum[0], r_mplr[WIDTH-1:1]};
          r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_count == LAST_CNT) begin
            r_state <= ST_SIGN;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_SIGN: begin
          r_hi    <= w_prod[2*WIDTH-1:WIDTH];
          r_lo    <= w_prod[WIDTH-1:0];
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: spec vectors, corner sequences, random ops.
module tb_mult_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  // Reference: plain integer multiply at 64 bits.
  function automatic logic [63:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, logic s);
    longint pa;
    longint pb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Present a request for one cycle, then scramble operands.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.is_signed = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.is_signed = 1'($urandom);
  endtask

  // Wait for done; lat counts cycles since the start cycle.
  task automatic wait_done(input int pulse_at, input logic chk_hold, input logic [63:0] hold,
                           output int lat, output int nbusy, output int herr);
    lat = 1;
    nbusy = 0;
    herr = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) nbusy++;
      if (chk_hold && ({bus.hi, bus.lo} !== hold)) herr++;
      if (lat == pulse_at) begin
        bus.start = 1'b1;
        bus.a = 32'd9;
        bus.b = 32'd9;
        bus.is_signed = 1'b0;
      end else begin
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [63:0] exp);
    int lat;
    int nb;
    int he;
    launch(a, b, s);
    wait_done(0, 1'b0, 64'd0, lat, nb, he);
    chk({nm, "_lat"}, 64'(lat), 64'd34);
    chk({nm, "_busy"}, 64'(nb), 64'd33);
    chk({nm, "_prod"}, {bus.hi, bus.lo}, exp);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    int nb;
    int he;
    int ndone;
    int nbusy_after;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;

    vecs[0] = '{32'd6,        32'd7,        1'b0, 32'h00000000, 32'h0000002A};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{32'hFFFFFFFD, 32'd5,        1'b0, 32'h00000004, 32'hFFFFFFF1};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    vecs[5] = '{32'h80000000, 32'd1,        1'b1, 32'hFFFFFFFF, 32'h80000000};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                {vecs[i].hi, vecs[i].lo});
      @(negedge clk);
      chk($sformatf("vec%0d_donepulse", i), 64'(bus.done), 64'd0);
      chk($sformatf("vec%0d_hold", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
    end

    // Start while busy is ignored.
    launch(32'd3, 32'd4, 1'b0);
    wait_done(5, 1'b0, 64'd0, lat, nb, he);
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_prod", {bus.hi, bus.lo}, 64'd12);
    ndone = 0;
    nbusy_after = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nbusy_after++;
    end
    chk("ign_extra_done", 64'(ndone), 64'd0);
    chk("ign_busy_after", 64'(nbusy_after), 64'd0);

    // Reset mid-run.
    launch(32'd3, 32'd4, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_hilo", {bus.hi, bus.lo}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("mrst_idle", 64'(ndone), 64'd0);
    run_check("mrst_2x2", 32'd2, 32'd2, 1'b0, 64'd4);

    // Back-to-back: new start in the done cycle.
    @(negedge clk);
    launch(32'd2, 32'd3, 1'b0);
    wait_done(0, 1'b0, 64'd0, lat, nb, he);
    chk("b2b_lat1", 64'(lat), 64'd34);
    chk("b2b_prod1", {bus.hi, bus.lo}, 64'd6);
    launch(32'd5, 32'd5, 1'b0);
    wait_done(0, 1'b1, 64'd6, lat, nb, he);
    chk("b2b_lat2", 64'(lat), 64'd34);
    chk("b2b_hold", 64'(he), 64'd0);
    chk("b2b_prod2", {bus.hi, bus.lo}, 64'd25);

    // Randomized operations against the reference.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'd0;
      run_check($sformatf("rnd%0d", i), ra, rb, rs, ref_mul(ra, rb, rs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
Multi-cycle shift-and-add multiplier for the MIPS MULT/MULTU path.
- Captures two WIDTH-bit register-file operands and iterates one partial-product add per clock through a WIDTH-bit ripple adder.
- Produces a 2*WIDTH-bit product split into HI/LO for the HI/LO register stage.
- Sits between ID/EX operand delivery and the HI/LO write port.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk       input   1        rising-edge clock
rst       input   1        synchronous reset, active-high
start     input   1        request a multiply; accepted only when busy=0
is_signed input   1        1 = MULT (two's complement), 0 = MULTU; sampled with start
a         input   WIDTH    multiplicand; sampled with start
b         input   WIDTH    multiplier; sampled with start
busy      output  1        operation in progress
done      output  1        one-cycle pulse; hi/lo hold the new product
hi        output  WIDTH    upper half of product
lo        output  WIDTH    lower half of product

Behaviour:
- Reset (sync, high, one clk edge): state=IDLE; busy, done, hi, lo and all internal registers = 0. Reset overrides everything, including mid-RUN; no partial result is written to hi/lo.
- States: IDLE, RUN, SIGN, DONE.
- Output flags:
  - busy=1 in RUN and SIGN only.
  - done=1 in DONE only.
- IDLE or DONE with start=1 -> RUN. On that edge:
  - Capture mag_a and mag_b. When is_signed=1, each is the absolute value of its operand; otherwise the raw operand.
  - Capture neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear acc (WIDTH+1 bits). Load the multiplier shift register with mag_b. Set count=0.
- IDLE with start=0 stays IDLE. DONE with start=0 -> IDLE.
- RUN, each cycle:
  - sum = acc[WIDTH-1:0] + (mplr[0] ? mag_a : 0), carry kept as bit WIDTH.
  - {acc, mplr} is then shifted right one place, with the carry entering the MSB.
  - count increments. After WIDTH RUN cycles -> SIGN.
- SIGN (1 cycle): product P = {acc, mplr} (2*WIDTH bits).
  - If neg=1, P = ~P + 1 (mod 2^(2*WIDTH)).
  - Write hi=P[2W-1:W], lo=P[W-1:0] -> DONE.
- Latency: start sampled high in cycle N gives done=1 in cycle N+WIDTH+2 (34 for WIDTH=32). Throughput is one product per WIDTH+2 cycles with back-to-back starts.
- start while busy=1 is ignored; it is neither queued nor does it disturb the operation in flight.
- Operand and is_signed changes after the start cycle have no effect.
- hi/lo change only on the SIGN->DONE edge or on reset. They hold the last product indefinitely.
- start in the DONE cycle is accepted: done still pulses for that cycle, and the new operation proceeds.
- Signed edge case: the magnitude of the most-negative value 0x80000000 is 2^31 as an unsigned WIDTH-bit value, and the result is still correct.
- All arithmetic is unsigned on magnitudes. Overflow is impossible: the product of two WIDTH-bit magnitudes always fits in 2*WIDTH bits.

Decomposition:
- Shared package (mult_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_SIGN=2'd2, ST_DONE=2'd3
  - default WIDTH/CNT_W
- One sub-module, mult_add_stage: a combinational WIDTH-bit adder with carry-out, built from the team's ripple full-adder cells. It takes acc[WIDTH-1:0] and the gated mag_a and returns {carry, sum}.
- Operand negation and final two's-complement fix-up are inline (invert plus increment). No separate module is needed.

Test Plan:
- MULTU a=6, b=7: start 1 cycle -> busy high 33 cycles, done at start+34, hi=0x00000000, lo=0x0000002A.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. The same operands as MULTU -> hi=0x00000004, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Start 3*4 and pulse start with a=9, b=9 at cycle +5 while busy -> the second start is ignored; lo=12, a single done, busy then stays low.
- Start 3*4, assert rst at cycle +10 -> next cycle busy=0, done=0, hi=lo=0, state IDLE. A subsequent 2*2 gives lo=4 with full latency.
- Back-to-back: 2*3, then start 5*5 in the done cycle -> done pulses at +34 (lo=6) and +68 (lo=25). hi/lo hold 6 between the two.
